input_check_state: RTL and testbench

- Player-side counterpart of the colour display stream. After the display phase, it accepts one button press per colour and checks each press against the packed sequence, for positions 0..round_ctr.
- Echoes each accepted press on a 2-bit colour bus with an output enable.
- Ends each round with a single-cycle complete_input pulse (all colours correct) or fail_input pulse (wrong colour or timeout) to the top-level game FSM.

---
 rtl/input_check_state.sv | 144 ++++++++++++++
 tb/tb_input_check_state.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_check_state.sv
// Player input checker: accepts one debounced button press per colour, echoes it,
// and ends the round with a one-cycle complete or fail pulse to the game FSM.
module input_check_state #(
  parameter int unsigned          TIMER_W        = 24,
  parameter logic [TIMER_W-1:0]   TIMEOUT_CYCLES = TIMER_W'(5_000_000)
) (
  input  logic        clk,
  input  logic        rst_input,
  input  logic        en_input,
  input  logic [31:0] seq_in_input,
  input  logic [3:0]  round_ctr,
  input  logic [3:0]  btn,
  output logic [1:0]  echo_colour,
  output logic        echo_oe,
  output logic        busy,
  output logic [3:0]  progress,
  output logic        complete_input,
  output logic        fail_input
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] WAIT_PRESS   = 2'd1;
  localparam logic [1:0] WAIT_RELEASE = 2'd2;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMEOUT_CYCLES - TIMER_W'(1);

  logic [1:0]         state, state_n;
  logic [3:0]         pos, pos_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic [3:0]         btn_q;
  logic [1:0]         echo_colour_n;
  logic               echo_oe_n, complete_n, fail_n;

  logic               one_hot_c, press_c, timer_last_c, match_c;
  logic [1:0]         colour_c, exp_colour_c;

  // Press decode: a single fresh button edge; held or chorded buttons never count
  always_comb begin
    one_hot_c = 1'b1;
    colour_c  = 2'd0;
    case (btn)
      4'b0001: colour_c = 2'd0;
      4'b0010: colour_c = 2'd1;
      4'b0100: colour_c = 2'd2;
      4'b1000: colour_c = 2'd3;
      default: one_hot_c = 1'b0;
    endcase
    press_c      = one_hot_c && (btn_q == 4'd0);
    exp_colour_c = seq_in_input[{pos, 1'b0} +: 2];
    match_c      = (colour_c == exp_colour_c);
    timer_last_c = (timer == TIMER_LAST);
  end

  // Next-state and registered-output decisions
  always_comb begin
    state_n       = state;
    pos_n         = pos;
    timer_n       = timer;
    echo_colour_n = echo_colour;
    echo_oe_n     = echo_oe;
    complete_n    = 1'b0;
    fail_n        = 1'b0;

    case (state)
      IDLE: begin
        echo_oe_n = 1'b0;
        if (en_input) begin
          state_n = WAIT_PRESS;
          pos_n   = 4'd0;
          timer_n = '0;
        end
      end

      WAIT_PRESS: begin
        timer_n = timer + TIMER_W'(1);
        if (press_c) begin
          echo_colour_n = colour_c;
          echo_oe_n     = 1'b1;
          if (match_c) begin
            timer_n = '0;
            state_n = WAIT_RELEASE;
          end else begin
            fail_n  = 1'b1;
            state_n = IDLE;
          end
        end else if (timer_last_c) begin
          fail_n  = 1'b1;
          state_n = IDLE;
        end
      end

      WAIT_RELEASE: begin
        timer_n   = timer + TIMER_W'(1);
        echo_oe_n = 1'b1;
        if (btn == 4'd0) begin
          echo_oe_n = 1'b0;
          timer_n   = '0;
          if (pos == round_ctr) begin
            complete_n = 1'b1;
            state_n    = IDLE;
          end else begin
            pos_n   = pos + 4'd1;
            state_n = WAIT_PRESS;
          end
        end else if (timer_last_c) begin
          fail_n    = 1'b1;
          echo_oe_n = 1'b0;
          state_n   = IDLE;
        end
      end

      default: begin
        state_n   = IDLE;
        echo_oe_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_input) begin
    if (rst_input) begin
      state          <= IDLE;
      pos            <= 4'd0;
      timer          <= '0;
      btn_q          <= 4'd0;
      echo_colour    <= 2'd0;
      echo_oe        <= 1'b0;
      complete_input <= 1'b0;
      fail_input     <= 1'b0;
    end else begin
      state          <= state_n;
      pos            <= pos_n;
      timer          <= timer_n;
      btn_q          <= btn;
      echo_colour    <= echo_colour_n;
      echo_oe        <= echo_oe_n;
      complete_input <= complete_n;
      fail_input     <= fail_n;
    end
  end

  assign busy     = (state != IDLE);
  assign progress = pos;

endmodule

// File: tb/tb_input_check_state.sv
// Scoreboard bench for input_check_state: the driver predicts echo/complete/fail
// events with their cycle stamps; a negedge monitor pops and compares them.
module tb_input_check_state;

  localparam int TO = 16;

  localparam int EV_ECHO = 0;
  localparam int EV_DONE = 1;
  localparam int EV_FAIL = 2;

  logic        clk = 1'b0;
  logic        rst_input;
  logic        en_input;
  logic [31:0] seq_in_input;
  logic [3:0]  round_ctr;
  logic [3:0]  btn;
  logic [1:0]  echo_colour;
  logic        echo_oe, busy, complete_input, fail_input;
  logic [3:0]  progress;

  input_check_state #(.TIMER_W(24), .TIMEOUT_CYCLES(24'd16)) dut (
    .clk(clk), .rst_input(rst_input), .en_input(en_input),
    .seq_in_input(seq_in_input), .round_ctr(round_ctr), .btn(btn),
    .echo_colour(echo_colour), .echo_oe(echo_oe), .busy(busy),
    .progress(progress), .complete_input(complete_input), .fail_input(fail_input)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [1:0] col;
    logic [3:0] prog;
    logic       oe;
    logic       bsy;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int mon_checks = 0, mon_errors = 0;
  int drv_checks = 0, drv_errors = 0;

  function automatic void push(int kind, logic [1:0] col, logic [3:0] prog,
                               logic oe, logic bsy, int c);
    exp_t e;
    e.kind = kind; e.col = col; e.prog = prog; e.oe = oe; e.bsy = bsy; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  function automatic void chk(string name, int act, int exp);
    drv_checks++;
    if (act != exp) begin
      drv_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic handle(int kind);
    exp_t e;
    bit   ok;
    mon_checks++;
    if (exp_q.size() == 0) begin
      mon_errors++;
      $display("FAIL unexpected_event kind=%0d at cycle %0d", kind, cyc);
      return;
    end
    e  = exp_q.pop_front();
    ok = (e.kind == kind) && (e.cyc == cyc) && (e.prog == progress) && (e.bsy == busy);
    if (kind == EV_ECHO) ok = ok && (echo_colour == e.col);
    if (kind == EV_FAIL) ok = ok && (echo_oe == e.oe);
    if (!ok) begin
      mon_errors++;
      $display("FAIL event: got kind=%0d cyc=%0d prog=%0d busy=%0d col=%0d oe=%0d expected kind=%0d cyc=%0d prog=%0d busy=%0d col=%0d oe=%0d",
               kind, cyc, progress, busy, echo_colour, echo_oe,
               e.kind, e.cyc, e.prog, e.bsy, e.col, e.oe);
    end
  endtask

  // Monitor: echo on echo_oe rising, plus every complete/fail pulse
  initial begin
    logic prev_oe;
    prev_oe = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_input) begin
        prev_oe = 1'b0;
      end else begin
        if (complete_input && fail_input) begin
          mon_checks++;
          mon_errors++;
          $display("FAIL pulse_exclusive: both complete and fail at cycle %0d", cyc);
        end
        if (echo_oe && !prev_oe) handle(EV_ECHO);
        if (complete_input) handle(EV_DONE);
        if (fail_input) handle(EV_FAIL);
        prev_oe = echo_oe;
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns the cycle on which WAIT_PRESS is entered
  task automatic start(input logic [31:0] seq, input int rc, output int entry);
    seq_in_input = seq;
    round_ctr    = 4'(rc);
    en_input     = 1'b1;
    entry        = cyc + 1;
    step(1);
    en_input     = 1'b0;
  endtask

  // err_kind: 0 none, 1 wrong colour, 2 timeout waiting for press, 3 stuck button
  task automatic run_round(input logic [31:0] seq, input int rc, input int err_pos,
                           input int err_kind, input logic [1:0] err_xor);
    int last, tp, tr;
    logic [1:0] col;
    start(seq, rc, last);
    for (int k = 0; k <= rc; k++) begin
      step($urandom_range(0, 3));
      if (err_kind == 2 && k == err_pos) begin
        push(EV_FAIL, 2'd0, 4'(k), 1'b0, 1'b0, last + TO);
        step(TO + 2);
        return;
      end
      col = seq[2*k +: 2];
      if (err_kind == 1 && k == err_pos) col = col ^ err_xor;
      btn = 4'b0001 << col;
      tp  = cyc;
      if (err_kind == 1 && k == err_pos) begin
        push(EV_ECHO, col, 4'(k), 1'b1, 1'b0, tp + 1);
        push(EV_FAIL, col, 4'(k), 1'b1, 1'b0, tp + 1);
        step(1);
        btn = 4'd0;
        step(2);
        chk("idle_after_wrong_busy", int'(busy), 0);
        return;
      end
      push(EV_ECHO, col, 4'(k), 1'b1, 1'b1, tp + 1);
      if (err_kind == 3 && k == err_pos) begin
        push(EV_FAIL, col, 4'(k), 1'b0, 1'b0, tp + 1 + TO);
        step(TO + 4);
        btn = 4'd0;
        step(2);
        return;
      end
      step($urandom_range(1, 4));
      btn = 4'd0;
      tr  = cyc;
      if (k == rc) push(EV_DONE, 2'd0, 4'(rc), 1'b0, 1'b0, tr + 1);
      else last = tr + 1;
      step(1);
    end
    step(2);
  endtask

  initial begin
    int entry, tp, tr;
    logic [31:0] seq;
    int rc, ek;

    rst_input = 1'b1; en_input = 1'b0; seq_in_input = '0; round_ctr = '0; btn = '0;
    step(2);
    chk("rst_echo_oe", int'(echo_oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_progress", int'(progress), 0);
    chk("rst_pulses", int'({complete_input, fail_input}), 0);
    rst_input = 1'b0;
    step(2);

    // Correct round, wrong colour, press timeout, stuck button
    run_round(32'h0000_00E4, 3, 0, 0, 2'd0);
    run_round(32'h0000_00E4, 3, 1, 1, 2'd3);
    run_round(32'h0000_00E4, 3, 0, 2, 2'd0);
    run_round(32'h0000_00E4, 3, 0, 3, 2'd0);
    run_round(32'h0000_00E4, 3, 2, 2, 2'd0);

    // Chorded press ignored, then a clean single press is accepted
    seq = $urandom;
    start(seq, 0, entry);
    btn = 4'b0011;
    step(3);
    btn = 4'd0;
    step(1);
    btn = 4'b0001 << seq[1:0];
    tp  = cyc;
    push(EV_ECHO, seq[1:0], 4'd0, 1'b1, 1'b1, tp + 1);
    step(2);
    btn = 4'd0;
    tr  = cyc;
    push(EV_DONE, 2'd0, 4'd0, 1'b0, 1'b0, tr + 1);
    step(3);

    // Button held from before the round start must be released first
    seq = $urandom;
    btn = 4'b0001 << seq[1:0];
    step(2);
    start(seq, 0, entry);
    step(3);
    chk("held_progress", int'(progress), 0);
    chk("held_no_echo", int'(echo_oe), 0);
    btn = 4'd0;
    step(1);
    btn = 4'b0001 << seq[1:0];
    tp  = cyc;
    push(EV_ECHO, seq[1:0], 4'd0, 1'b1, 1'b1, tp + 1);
    step(2);
    btn = 4'd0;
    tr  = cyc;
    push(EV_DONE, 2'd0, 4'd0, 1'b0, 1'b0, tr + 1);
    step(3);

    // Single colour round; en_input pulsed while busy is ignored
    start(32'h0000_0003, 0, entry);
    btn = 4'b1000;
    tp  = cyc;
    push(EV_ECHO, 2'd3, 4'd0, 1'b1, 1'b1, tp + 1);
    step(1);
    en_input = 1'b1;
    step(1);
    en_input = 1'b0;
    step(1);
    btn = 4'd0;
    tr  = cyc;
    push(EV_DONE, 2'd0, 4'd0, 1'b0, 1'b0, tr + 1);
    step(TO + 6);
    chk("en_ignored_busy", int'(busy), 0);

    // Randomized rounds
    for (int r = 0; r < 30; r++) begin
      seq = $urandom;
      rc  = (r == 0) ? 15 : $urandom_range(0, 7);
      ek  = $urandom_range(0, 5);
      ek  = (ek < 3) ? 0 : ek - 2;
      if (r == 0) ek = 0;
      run_round(seq, rc, $urandom_range(0, rc), ek, 2'($urandom_range(1, 3)));
    end

    // Asynchronous reset mid WAIT_RELEASE with echo active
    start(32'h0000_00E4, 3, entry);
    btn = 4'b0001;
    tp  = cyc;
    push(EV_ECHO, 2'd0, 4'd0, 1'b1, 1'b1, tp + 1);
    step(2);
    chk("pre_rst_echo_oe", int'(echo_oe), 1);
    #2 rst_input = 1'b1;
    #1;
    chk("async_rst_echo_oe", int'(echo_oe), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_echo_colour", int'(echo_colour), 0);
    chk("async_rst_progress", int'(progress), 0);
    chk("async_rst_pulses", int'({complete_input, fail_input}), 0);
    btn = 4'd0;
    step(2);
    rst_input = 1'b0;
    step(TO + 6);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             mon_checks + drv_checks, mon_errors + drv_errors);
    $finish;
  end

endmodule
